sim_exit_controller: RTL and testbench

//  Testbench-side end-of-simulation sequencer. Arbitrates pass/fail exit requests from N

---
 rtl/exit_impl.sv | 13 +
 rtl/sim_exit_pkg.sv | 10 +
 rtl/sim_exit_arbiter.sv | 38 +++
 rtl/sim_exit_controller.sv | 128 ++++++++++++
 tb/tb_sim_exit_controller.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exit_impl.sv
// Simulation exit primitives; the only place that actually ends a run.
package exit_impl;

  task automatic verilator_compatible_exit(input logic status);
    if (status) $fatal(1, "sim_exit: run ended with failing status");
    else $finish;
  endtask

  task automatic fatal_exit();
    $fatal(1, "sim_exit: fatal exit requested on failing status");
  endtask

endpackage

// File: rtl/sim_exit_pkg.sv
// Shared types and sizing helpers for the end-of-simulation sequencer.
package sim_exit_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_REPORT, ST_EXITED} sim_exit_state_e;

  function automatic int winner_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sim_exit_arbiter.sv
// Combinational exit-request arbiter: any fail request beats any pass request,
// then the lowest index wins. Produces a one-hot grant plus its index.
module sim_exit_arbiter
  import sim_exit_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]             valid_i,
  input  logic [N_REQ-1:0]             fail_i,
  output logic [N_REQ-1:0]             grant_o,
  output logic [winner_w(N_REQ)-1:0]   idx_o,
  output logic                         any_o,
  output logic                         is_fail_o
);

  localparam int WIN_W = winner_w(N_REQ);

  logic [N_REQ-1:0] fail_req;
  logic [N_REQ-1:0] pool;

  always_comb begin
    fail_req  = valid_i & fail_i;
    pool      = (|fail_req) ? fail_req : valid_i;
    grant_o   = '0;
    idx_o     = '0;
    any_o     = |valid_i;
    is_fail_o = |fail_req;
    // Scan downwards so the lowest set index is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = WIN_W'(i);
      end
    end
  end

endmodule

// File: rtl/sim_exit_controller.sv
// End-of-simulation sequencer: arbitrates exit requests, runs a heartbeat
// watchdog, drains in-flight traffic, then fires exactly one exit.
module sim_exit_controller
  import sim_exit_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32,
  parameter int CALL_EXIT      = 1,
  parameter int FATAL_ON_FAIL  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_fail,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       heartbeat,
  input  logic                       busy,
  output logic                       done,
  output logic                       exit_fire,
  output logic                       exit_status,
  output logic [winner_w(N_REQ)-1:0] winner,
  output logic [CNT_W-1:0]           err_count
);

  localparam int                 WIN_W      = winner_w(N_REQ);
  localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam bit                 WD_EN      = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]   WD_LAST    = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  sim_exit_state_e    state_q;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [WIN_W-1:0]   winner_q;
  logic               done_q, exit_fire_q, exit_status_q;

  logic [N_REQ-1:0]   grant;
  logic [WIN_W-1:0]   grant_idx;
  logic               grant_any, grant_fail;
  logic               active, accept, accept_fail, wd_hit, drain_hit;

  sim_exit_arbiter #(.N_REQ(N_REQ)) u_arb (
    .valid_i   (req_valid),
    .fail_i    (req_fail),
    .grant_o   (grant),
    .idx_o     (grant_idx),
    .any_o     (grant_any),
    .is_fail_o (grant_fail)
  );

  always_comb begin
    active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    accept      = active && grant_any;
    accept_fail = accept && grant_fail;
    // A heartbeat in the limit cycle rescues the run; the window then restarts.
    wd_hit      = WD_EN && active && !heartbeat && (wd_q == WD_LAST);
    drain_hit   = (state_q == ST_DRAIN) && !busy && (drain_q == DRAIN_LAST);
    wd_d        = (!WD_EN || heartbeat || (wd_q == WD_LAST)) ? '0 : wd_q + 1'b1;
    err_d       = (&err_q) ? err_q : err_q + 1'b1;
  end

  assign req_ready   = (active && rst_n) ? grant : '0;
  assign done        = done_q;
  assign exit_fire   = exit_fire_q;
  assign exit_status = exit_status_q;
  assign winner      = winner_q;
  assign err_count   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wd_q          <= '0;
      err_q         <= '0;
      drain_q       <= '0;
      winner_q      <= '0;
      done_q        <= 1'b0;
      exit_fire_q   <= 1'b0;
      exit_status_q <= 1'b0;
    end else begin
      exit_fire_q <= 1'b0;
      if (active) begin
        wd_q <= wd_d;
        if (accept_fail) begin
          err_q         <= err_d;
          exit_status_q <= 1'b1;
        end
        if (wd_hit) exit_status_q <= 1'b1;
      end
      unique case (state_q)
        ST_RUN: begin
          if (accept) begin
            winner_q <= grant_idx;
            state_q  <= ST_DRAIN;
          end else if (wd_hit) begin
            winner_q <= WIN_W'(N_REQ);
            state_q  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!busy) drain_q <= drain_q + 1'b1;
          // A watchdog hit here means traffic is stuck busy: report immediately.
          if (wd_hit || drain_hit) begin
            state_q     <= ST_REPORT;
            exit_fire_q <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        ST_REPORT: state_q <= ST_EXITED;
        default:   state_q <= ST_EXITED;
      endcase
    end
  end

  generate
    if (CALL_EXIT != 0 || FATAL_ON_FAIL != 0) begin : g_exit
      always @(posedge clk) begin
        if (exit_fire_q) begin
          if (exit_status_q && FATAL_ON_FAIL != 0) exit_impl::fatal_exit();
          if (CALL_EXIT != 0) exit_impl::verilator_compatible_exit(exit_status_q);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sim_exit_controller.sv
// Directed bench for sim_exit_controller against a behavioural model of the exit rules.
module tb_sim_exit_controller;

  localparam int NREQ    = 4;
  localparam int DRAIN   = 4;
  localparam int TIMEOUT = 100;
  localparam int ERR_MAX = 255;
  localparam int P_RUN = 0, P_DRAIN = 1, P_REPORT = 2, P_EXITED = 3;

  typedef struct {
    int phase;
    bit done;
    bit fire;
    bit status;
    int winner;
    int err;
    int wd;
    int idle;
  } m_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_fail = '0;
  logic [3:0] req_ready;
  logic       heartbeat = 1'b0;
  logic       busy = 1'b0;
  logic       done, exit_fire, exit_status;
  logic [2:0] winner;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fire_cnt = 0;
  int fire_cyc = 0;
  int c0 = 0;
  bit chk_en = 0;
  m_t m;

  sim_exit_controller #(
    .N_REQ(NREQ), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(8), .CALL_EXIT(0), .FATAL_ON_FAIL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_fail(req_fail),
    .req_ready(req_ready), .heartbeat(heartbeat), .busy(busy), .done(done),
    .exit_fire(exit_fire), .exit_status(exit_status), .winner(winner),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(logic [3:0] v, logic [3:0] f);
    for (int i = 0; i < NREQ; i++) if (v[i] && f[i]) return i;
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic m_t model_next(m_t s, logic [3:0] v, logic [3:0] f, logic hb, logic bz);
    m_t n;
    int g;
    bit hit;
    n = s;
    n.fire = 0;
    if (s.phase == P_REPORT) n.phase = P_EXITED;
    if (s.phase == P_RUN || s.phase == P_DRAIN) begin
      g = pick(v, f);
      hit = !hb && (s.wd == TIMEOUT - 1);
      n.wd = hb ? 0 : (s.wd + 1) % TIMEOUT;
      if (g >= 0 && f[g]) begin
        n.err = (s.err < ERR_MAX) ? s.err + 1 : ERR_MAX;
        n.status = 1;
      end
      if (hit) n.status = 1;
      if (s.phase == P_RUN) begin
        if (g >= 0) begin
          n.winner = g;
          n.phase = P_DRAIN;
        end else if (hit) begin
          n.winner = NREQ;
          n.phase = P_DRAIN;
        end
      end else begin
        if (!bz) n.idle = s.idle + 1;
        if (hit || n.idle == DRAIN) begin
          n.phase = P_REPORT;
          n.fire = 1;
          n.done = 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{phase: P_RUN, default: 0};
    else m <= model_next(m, req_valid, req_fail, heartbeat, busy);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int g;
    logic [3:0] er;
    forever begin
      @(negedge clk);
      if (exit_fire === 1'b1) begin
        fire_cnt++;
        fire_cyc = cyc;
      end
      if (chk_en) begin
        er = '0;
        if (rst_n && (m.phase == P_RUN || m.phase == P_DRAIN)) begin
          g = pick(req_valid, req_fail);
          if (g >= 0) er[g] = 1'b1;
        end
        check("cmp_ready", req_ready, er);
        check("cmp_done", done, m.done);
        check("cmp_fire", exit_fire, m.fire);
        check("cmp_status", exit_status, m.status);
        check("cmp_winner", winner, m.winner);
        check("cmp_err", err_count, m.err);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_fail = 4'b0101;
    heartbeat = 1'b0;
    busy = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_fire", exit_fire, 0);
    check("rst_status", exit_status, 0);
    check("rst_winner", winner, 0);
    check("rst_err", err_count, 0);
    chk_en = 1;
    tick(2);
    req_valid = '0;
    req_fail = '0;
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_fire(input string name, input int limit);
    int n0;
    bit seen;
    n0 = fire_cnt;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (fire_cnt != n0) seen = 1;
    end
    check({name, "_fire_seen"}, seen, 1);
  endtask

  task automatic pulse_req(input logic [3:0] v, input logic [3:0] f, input string name,
                           input logic [3:0] exp_ready, output int t0);
    t0 = cyc;
    req_valid = v;
    req_fail = f;
    #1;
    check({name, "_ready"}, req_ready, exp_ready);
    tick(1);
    req_valid = '0;
    req_fail = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, n0, tb;
    #2;

    // Single pass request; fire five cycles after it is presented.
    do_reset();
    tick(3);
    pulse_req(4'b0100, 4'b0000, "t1", 4'b0100, t0);
    wait_fire("t1", 20);
    check("t1_latency", fire_cyc - t0, 5);
    check("t1_status", exit_status, 0);
    check("t1_winner", winner, 2);
    check("t1_err", err_count, 0);
    req_valid = 4'b1111;
    req_fail = 4'b1111;
    #1;
    check("t1_exited_ready", req_ready, 0);
    tick(3);
    check("t1_exited_err", err_count, 0);
    check("t1_exited_done", done, 1);
    req_valid = '0;
    req_fail = '0;

    // Fail beats a lower-index pass in the same cycle.
    do_reset();
    tick(2);
    pulse_req(4'b1010, 4'b1000, "t2", 4'b1000, t0);
    wait_fire("t2", 20);
    check("t2_latency", fire_cyc - t0, 5);
    check("t2_winner", winner, 3);
    check("t2_status", exit_status, 1);
    check("t2_err", err_count, 1);

    // Watchdog timeout in RUN with nothing else happening.
    do_reset();
    wait_fire("t3", 150);
    check("t3_latency", fire_cyc - c0, 104);
    check("t3_winner", winner, 4);
    check("t3_status", exit_status, 1);
    check("t3_err", err_count, 0);

    // Regular heartbeats keep the run alive; then a clean pass.
    do_reset();
    n0 = fire_cnt;
    for (int i = 0; i < 1000; i++) begin
      heartbeat = (i % 50 == 49);
      tick(1);
    end
    heartbeat = 1'b0;
    check("t4_alive_done", done, 0);
    check("t4_alive_nofire", fire_cnt, n0);
    pulse_req(4'b0001, 4'b0000, "t4", 4'b0001, t0);
    wait_fire("t4", 20);
    check("t4_status", exit_status, 0);
    check("t4_winner", winner, 0);

    // Busy holds the drain; a fail accepted in DRAIN flips status only.
    do_reset();
    tick(2);
    busy = 1'b1;
    pulse_req(4'b0001, 4'b0000, "t5a", 4'b0001, t0);
    tick(3);
    pulse_req(4'b0010, 4'b0010, "t5b", 4'b0010, t0);
    tick(15);
    busy = 1'b0;
    tb = cyc;
    wait_fire("t5", 20);
    check("t5_latency", fire_cyc - tb, 4);
    check("t5_status", exit_status, 1);
    check("t5_winner", winner, 0);
    check("t5_err", err_count, 1);

    // Reset in the middle of DRAIN aborts the exit.
    do_reset();
    tick(2);
    pulse_req(4'b0100, 4'b0100, "t6a", 4'b0100, t0);
    tick(2);
    check("t6_pre_winner", winner, 2);
    n0 = fire_cnt;
    do_reset();
    tick(10);
    check("t6_abort_nofire", fire_cnt, n0);
    check("t6_abort_done", done, 0);
    pulse_req(4'b1000, 4'b0000, "t6b", 4'b1000, t0);
    wait_fire("t6", 20);
    check("t6_winner", winner, 3);
    check("t6_status", exit_status, 0);

    // Error counter saturates at its all-ones value.
    do_reset();
    heartbeat = 1'b1;
    busy = 1'b1;
    req_valid = 4'b0001;
    req_fail = 4'b0001;
    tick(300);
    check("t7_sat", err_count, 255);
    req_valid = '0;
    req_fail = '0;
    busy = 1'b0;
    heartbeat = 1'b0;
    wait_fire("t7", 20);
    check("t7_err", err_count, 255);
    check("t7_status", exit_status, 1);
    check("t7_winner", winner, 0);

    // Stuck busy: watchdog forces REPORT straight from DRAIN.
    do_reset();
    tick(2);
    busy = 1'b1;
    pulse_req(4'b0001, 4'b0000, "t8", 4'b0001, t0);
    wait_fire("t8", 200);
    busy = 1'b0;
    check("t8_latency", fire_cyc - c0, 100);
    check("t8_status", exit_status, 1);
    check("t8_winner", winner, 0);
    check("t8_err", err_count, 0);

    // Heartbeat in the limit cycle wins and restarts the window.
    do_reset();
    tick(99);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    tick(5);
    check("t9_saved_done", done, 0);
    wait_fire("t9", 300);
    check("t9_latency", fire_cyc - c0, 204);
    check("t9_winner", winner, 4);
    check("t9_status", exit_status, 1);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
